// File: rtl/room_draw_scheduler.sv
// Round-robin scheduler for per-room redraw jobs and full-screen clears on the shared VGA drawer.
// Each completed room job produces one audio cue.
module room_draw_scheduler #(
    parameter int NUM_ROOMS = 5,
    parameter int TIMEOUT   = 20000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_room,
    input  logic       req_funct,
    input  logic       req_onoff,
    input  logic       clear_req,
    input  logic       countDone,
    output logic       draw_start,
    output logic       draw_clear,
    output logic [7:0] draw_x,
    output logic [6:0] draw_y,
    output logic [2:0] draw_colour,
    output logic       aud_valid,
    output logic [3:0] aud_code,
    output logic [4:0] pending,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [2:0] {IDLE, ARB, START, WAIT, AUDIO, CLR_START, CLR_WAIT} state_t;

    localparam int ROOMS = (NUM_ROOMS < 5) ? NUM_ROOMS : 5;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic [4:0]    room_funct;
    logic [4:0]    room_onoff;
    logic          clear_pend;
    logic [2:0]    last_grant;
    logic          job_funct;
    logic          job_onoff;
    logic [TW-1:0] timer;

    logic          req_ok;
    logic          grant_found;
    logic [2:0]    grant_room;
    logic [2:0]    idx;
    logic          sel_funct;
    logic          sel_onoff;

    function automatic logic [2:0] colour_of(input logic f, input logic o);
        if (f)
            return o ? 3'b110 : 3'b001;
        else
            return o ? 3'b100 : 3'b010;
    endfunction

    assign req_ok    = req_valid && (int'(req_room) < ROOMS);
    assign busy      = (state != IDLE);
    assign sel_funct = room_funct[grant_room];
    assign sel_onoff = room_onoff[grant_room];

    // Search starts just after the last granted room and wraps 4 -> 0.
    always_comb begin
        grant_found = 1'b0;
        grant_room  = 3'd0;
        idx         = 3'd0;
        for (int i = 1; i <= 5; i++) begin
            idx = 3'((int'(last_grant) + i) % 5);
            if (!grant_found && pending[idx]) begin
                grant_found = 1'b1;
                grant_room  = idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            pending     <= '0;
            room_funct  <= '0;
            room_onoff  <= '0;
            clear_pend  <= 1'b0;
            last_grant  <= 3'd4;
            job_funct   <= 1'b0;
            job_onoff   <= 1'b0;
            timer       <= '0;
            timeout_err <= 1'b0;
            draw_start  <= 1'b0;
            draw_clear  <= 1'b0;
            draw_x      <= 8'd0;
            draw_y      <= 7'd0;
            draw_colour <= 3'd0;
            aud_valid   <= 1'b0;
            aud_code    <= 4'd0;
        end else begin
            draw_start <= 1'b0;
            aud_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_pend) begin
                        draw_start  <= 1'b1;
                        draw_clear  <= 1'b1;
                        draw_x      <= 8'd0;
                        draw_y      <= 7'd0;
                        draw_colour <= 3'd0;
                        state       <= CLR_START;
                    end else if (|pending) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (grant_found) begin
                        job_funct           <= sel_funct;
                        job_onoff           <= sel_onoff;
                        pending[grant_room] <= 1'b0;
                        last_grant          <= grant_room;
                        draw_start          <= 1'b1;
                        draw_clear          <= 1'b0;
                        draw_x              <= 8'd10 + 8'd30 * {5'd0, grant_room};
                        draw_y              <= sel_funct ? 7'd40 : 7'd80;
                        draw_colour         <= colour_of(sel_funct, sel_onoff);
                        state               <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (countDone) begin
                        aud_valid <= 1'b1;
                        aud_code  <= {2'b00, ~job_funct, ~job_onoff};
                        state     <= AUDIO;
                    end else if (timer == TIMER_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                AUDIO: state <= IDLE;
                CLR_START: begin
                    pending    <= '0;
                    clear_pend <= 1'b0;
                    timer      <= '0;
                    state      <= CLR_WAIT;
                end
                CLR_WAIT: begin
                    if (countDone) begin
                        state <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // New requests come last so they win over same-cycle clears.
            if (clear_req)
                clear_pend <= 1'b1;
            if (req_ok) begin
                pending[req_room]    <= 1'b1;
                room_funct[req_room] <= req_funct;
                room_onoff[req_room] <= req_onoff;
            end
        end
    end

endmodule

// File: tb/tb_room_draw_scheduler.sv
// Directed bench for room_draw_scheduler: arbitration order, drawer parameters, audio cues,
// clear priority and the WAIT timeout, all against hand-computed values.
module tb_room_draw_scheduler;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_room;
    logic       req_funct;
    logic       req_onoff;
    logic       clear_req;
    logic       countDone;
    logic       draw_start;
    logic       draw_clear;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [2:0] draw_colour;
    logic       aud_valid;
    logic [3:0] aud_code;
    logic [4:0] pending;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int audCount;

    room_draw_scheduler #(.NUM_ROOMS(5), .TIMEOUT(16)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_room(req_room),
        .req_funct(req_funct),
        .req_onoff(req_onoff),
        .clear_req(clear_req),
        .countDone(countDone),
        .draw_start(draw_start),
        .draw_clear(draw_clear),
        .draw_x(draw_x),
        .draw_y(draw_y),
        .draw_colour(draw_colour),
        .aud_valid(aud_valid),
        .aud_code(aud_code),
        .pending(pending),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] room, input logic f, input logic o);
        req_valid = v;
        req_room  = room;
        req_funct = f;
        req_onoff = o;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitDrawStart(input string tag);
        int n;
        n = 0;
        while (draw_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checkOutput({tag, " draw_start"}, 32'(draw_start), 32'd1);
    endtask

    // Waits for the job's start pulse, checks drawer values, finishes it at once and checks the cue.
    task automatic runJob(input string tag, input logic [7:0] ex, input logic [6:0] ey,
                          input logic [2:0] ec, input logic [3:0] ecode);
        waitDrawStart(tag);
        checkOutput({tag, " x"}, 32'(draw_x), 32'(ex));
        checkOutput({tag, " y"}, 32'(draw_y), 32'(ey));
        checkOutput({tag, " colour"}, 32'(draw_colour), 32'(ec));
        checkOutput({tag, " clear"}, 32'(draw_clear), 32'd0);
        tick();
        countDone = 1'b1;
        tick();
        countDone = 1'b0;
        checkOutput({tag, " aud_valid"}, 32'(aud_valid), 32'd1);
        checkOutput({tag, " aud_code"}, 32'(aud_code), 32'(ecode));
        tick();
        checkOutput({tag, " aud_valid low"}, 32'(aud_valid), 32'd0);
        checkOutput({tag, " busy low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        clear_req = 1'b0;
        countDone = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        checkOutput("rst draw_start", 32'(draw_start), 32'd0);
        checkOutput("rst draw_clear", 32'(draw_clear), 32'd0);
        checkOutput("rst draw_x", 32'(draw_x), 32'd0);
        checkOutput("rst draw_y", 32'(draw_y), 32'd0);
        checkOutput("rst colour", 32'(draw_colour), 32'd0);
        checkOutput("rst aud_valid", 32'(aud_valid), 32'd0);
        checkOutput("rst aud_code", 32'(aud_code), 32'd0);
        checkOutput("rst pending", 32'(pending), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b1;
        tick();

        // Round-robin burst: rooms 0, 3, 4 granted in order 0, 3, 4
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd4, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        checkOutput("rr pending after first grant", 32'(pending), 32'h18);
        runJob("rr room0", 8'd10, 7'd40, 3'b110, 4'b0000);
        runJob("rr room3", 8'd100, 7'd80, 3'b010, 4'b0011);
        runJob("rr room4", 8'd130, 7'd40, 3'b001, 4'b0001);

        // Wrap: after room 4, rooms 3 and 0 are granted 0 then 3
        applyStimulus(1'b1, 3'd3, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        runJob("wrap room0", 8'd10, 7'd80, 3'b100, 4'b0010);
        runJob("wrap room3", 8'd100, 7'd40, 3'b110, 4'b0000);

        // Single request: room 2 LIGHT ON, exact start latency
        applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        checkOutput("single pending", 32'(pending), 32'h04);
        checkOutput("single start N", 32'(draw_start), 32'd0);
        tick();
        checkOutput("single start N+1", 32'(draw_start), 32'd0);
        checkOutput("single busy ARB", 32'(busy), 32'd1);
        tick();
        checkOutput("single start N+2", 32'(draw_start), 32'd1);
        checkOutput("single x", 32'(draw_x), 32'd70);
        checkOutput("single y", 32'(draw_y), 32'd40);
        checkOutput("single colour", 32'(draw_colour), 32'h6);
        repeat (4) tick();
        checkOutput("single no early cue", 32'(aud_valid), 32'd0);
        countDone = 1'b1;
        tick();
        countDone = 1'b0;
        checkOutput("single aud_valid", 32'(aud_valid), 32'd1);
        checkOutput("single aud_code", 32'(aud_code), 32'd0);
        checkOutput("single busy AUDIO", 32'(busy), 32'd1);
        tick();
        checkOutput("single busy drop", 32'(busy), 32'd0);
        checkOutput("single x held", 32'(draw_x), 32'd70);

        // Overwrite before grant: latest request wins, one job only
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        runJob("overwrite", 8'd40, 7'd80, 3'b010, 4'b0011);
        tick();
        checkOutput("overwrite single job", 32'(busy), 32'd0);
        checkOutput("overwrite pending", 32'(pending), 32'd0);

        // Request on the grant edge: set wins, room redrawn with the new value
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        checkOutput("setwins pending", 32'(pending), 32'h01);
        runJob("setwins first", 8'd10, 7'd40, 3'b110, 4'b0000);
        runJob("setwins redraw", 8'd10, 7'd40, 3'b001, 4'b0001);

        // Clear priority: clear pulsed while a job waits, room 4 pending
        applyStimulus(1'b1, 3'd2, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        waitDrawStart("clr job");
        applyStimulus(1'b1, 3'd4, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        countDone = 1'b1;
        tick();
        countDone = 1'b0;
        checkOutput("clr job aud_valid", 32'(aud_valid), 32'd1);
        checkOutput("clr job aud_code", 32'(aud_code), 32'h1);
        checkOutput("clr pending room4", 32'(pending), 32'h10);
        tick();
        tick();
        checkOutput("clr draw_start", 32'(draw_start), 32'd1);
        checkOutput("clr draw_clear", 32'(draw_clear), 32'd1);
        checkOutput("clr x", 32'(draw_x), 32'd0);
        checkOutput("clr y", 32'(draw_y), 32'd0);
        checkOutput("clr colour", 32'(draw_colour), 32'd0);
        tick();
        checkOutput("clr pending cleared", 32'(pending), 32'd0);
        checkOutput("clr start pulse", 32'(draw_start), 32'd0);
        countDone = 1'b1;
        tick();
        countDone = 1'b0;
        checkOutput("clr no audio", 32'(aud_valid), 32'd0);
        checkOutput("clr busy done", 32'(busy), 32'd0);
        tick();
        checkOutput("clr stays idle", 32'(busy), 32'd0);

        // Timeout after 16 WAIT cycles, next pending job proceeds
        applyStimulus(1'b1, 3'd3, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        waitDrawStart("tmo job");
        applyStimulus(1'b1, 3'd1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        audCount = 0;
        repeat (15) begin
            tick();
            if (aud_valid === 1'b1) audCount++;
        end
        checkOutput("tmo not yet", 32'(timeout_err), 32'd0);
        checkOutput("tmo still waiting", 32'(busy), 32'd1);
        tick();
        if (aud_valid === 1'b1) audCount++;
        checkOutput("tmo err set", 32'(timeout_err), 32'd1);
        checkOutput("tmo back idle", 32'(busy), 32'd0);
        checkOutput("tmo no audio", 32'(audCount), 32'd0);
        runJob("tmo next job", 8'd40, 7'd40, 3'b001, 4'b0001);
        checkOutput("tmo err sticky", 32'(timeout_err), 32'd1);

        // Reset during WAIT abandons the job and clears the sticky error
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        waitDrawStart("rstwait job");
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("rstwait busy", 32'(busy), 32'd0);
        checkOutput("rstwait err", 32'(timeout_err), 32'd0);
        checkOutput("rstwait x", 32'(draw_x), 32'd0);
        tick();
        checkOutput("rstwait no audio", 32'(aud_valid), 32'd0);

        // Out-of-range room and stray countDone in IDLE are ignored
        applyStimulus(1'b1, 3'd5, 1'b1, 1'b1);
        countDone = 1'b1;
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        countDone = 1'b0;
        checkOutput("oor pending", 32'(pending), 32'd0);
        tick();
        checkOutput("oor busy", 32'(busy), 32'd0);
        checkOutput("stray countDone", 32'(aud_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/room_draw_scheduler.md
# room_draw_scheduler

Sequences VGA redraw jobs and audio cues for the home-simulation display. Rooms 0-4 post light/door state updates. The block holds one pending job per room, grants jobs round-robin, drives the shared drawer with base coordinates and colour, and waits for `countDone`. It then emits one audio cue per completed job. It sits between the control path (request source) and the VGA drawing datapath and audio output.

## Interface
- `NUM_ROOMS`, default 5: number of rooms; `req_room` values at or above this are ignored.
- `TIMEOUT`, default 20000: maximum cycles spent in WAIT before the job is abandoned.
- `clock` input, 1 bit: system clock (CLOCK_50).
- `reset` input, 1 bit: synchronous, active-low; sampled on the rising edge of `clock`.
- `req_valid` input, 1 bit: one-cycle request strobe.
- `req_room` input, 3 bits: room number, 0-4.
- `req_funct` input, 1 bit: 1 = LIGHT, 0 = DOOR.
- `req_onoff` input, 1 bit: 1 = ON/locked, 0 = OFF/unlocked.
- `clear_req` input, 1 bit: strobe requesting a full-screen clear.
- `countDone` input, 1 bit: the drawer's done pulse.
- `draw_start` output, 1 bit: one-cycle start pulse to the drawer.
- `draw_clear` output, 1 bit: qualifies `draw_start` as a clear job.
- `draw_x` output, 8 bits: base x coordinate.
- `draw_y` output, 7 bits: base y coordinate.
- `draw_colour` output, 3 bits: colour for the job.
- `aud_valid` output, 1 bit: one-cycle audio cue strobe.
- `aud_code` output, 4 bits: audio cue code.
- `pending` output, 5 bits: per-room pending flags.
- `busy` output, 1 bit: high whenever the state is not IDLE.
- `timeout_err` output, 1 bit: sticky; cleared only by reset.

## Operation
- **Per-room storage:** `pending[r]`, `funct[r]`, `onoff[r]`.
  - An accepted `req_valid` sets `pending[req_room]` and overwrites that room's funct/onoff. The latest request wins.
  - Requests are accepted in every state.
- **Clear storage:** a `clear_pend` flag is set by `clear_req`.
- **FSM states:** IDLE, ARB, START, WAIT, AUDIO, CLR_START, CLR_WAIT.
- **IDLE:**
  - `clear_pend` set -> CLR_START (clear has priority over room jobs).
  - Else any `pending` bit set -> ARB.
  - Else stay in IDLE.
- **ARB:**
  - Grant the first set bit searching from `last_grant+1` upward, wrapping 4 -> 0.
  - Latch the granted room number, funct and onoff into job registers.
  - Clear that room's pending bit and update `last_grant`.
  - Go to START.
- **START:** `draw_start`=1 and `draw_clear`=0; go to WAIT.
- **WAIT:**
  - `countDone` -> AUDIO.
  - Timer reaches TIMEOUT-1 -> set `timeout_err` and go to IDLE with no audio cue.
- **AUDIO:** `aud_valid`=1 with the code for the job; go to IDLE.
- **CLR_START:**
  - `draw_start`=1 and `draw_clear`=1, with `draw_x`=0, `draw_y`=0, `draw_colour`=0.
  - Clear `clear_pend` and all `pending` bits.
  - Go to CLR_WAIT.
- **CLR_WAIT:**
  - `countDone` -> IDLE; a clear produces no audio cue.
  - Timeout behaves as in WAIT.
- **Coordinates:**
  - `draw_x` = 10 + 30·room, computed in 8-bit arithmetic; the maximum is 130.
  - `draw_y` = 40 for LIGHT, 80 for DOOR.
- **Colour:**
  - LIGHT ON = 3'b110, LIGHT OFF = 3'b001.
  - DOOR locked = 3'b100, DOOR unlocked = 3'b010.
- **Audio codes:** L-ON 4'b0000, L-OFF 4'b0001, D-ON 4'b0010, D-OFF 4'b0011. 4'b0100 is reserved for all-locked and is never produced by this block.
- **Output holding:** `draw_x`, `draw_y`, `draw_colour` and `draw_clear` are registered. They hold the job values from START until the next grant.

## Timing
- **Reset (`reset`=0 at an edge):**
  - State goes to IDLE.
  - `pending`, `clear_pend`, `timeout_err`, `draw_start`, `draw_clear`, `aud_valid` and `busy` = 0.
  - `draw_x`, `draw_y`, `draw_colour` and `aud_code` = 0.
  - `last_grant` = 4, so the first grant searches from room 0.
  - The WAIT timer = 0.
  - Reset during WAIT abandons the job without an audio cue or an error.
- **Request latency:**
  - `req_valid` sampled at edge N -> `pending` visible after N.
  - IDLE sees it -> ARB after N+1 -> `draw_start` high in the cycle after edge N+2.
- **Completion latency:**
  - `countDone` sampled in WAIT at edge M -> `aud_valid` high for the cycle after M.
  - IDLE after M+1.
- **Timer:** counts cycles in WAIT or CLR_WAIT and resets to 0 on entry to either state.
- **Ignored strobe:** `countDone` outside WAIT and CLR_WAIT is ignored.
- **Simultaneous events:**
  - ARB clears a room's pending bit in the same cycle `req_valid` targets that room: set wins, and the room is redrawn later.
  - `clear_req` in the same cycle as a CLR_START clear of `pending`: `clear_pend` stays set.
  - `req_valid` in the same cycle as a CLR_START clear of `pending`: that room's pending bit stays set.
- **Clear during a room job:** `clear_req` during WAIT lets the current job finish, including AUDIO, before the clear runs.
- **Out-of-range request:** `req_room` ≥ NUM_ROOMS is dropped with no state change.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles -> all outputs 0, `busy`=0.
- **Single request:** request room 2 LIGHT ON, drive `countDone` 5 cycles after START.
  - `draw_start` occurs exactly 3 cycles after the request edge.
  - `draw_x`=70, `draw_y`=40, `draw_colour`=3'b110.
  - One `aud_valid` with `aud_code`=4'b0000.
  - `busy` drops the cycle after AUDIO.
- **Round-robin:** post rooms 0, 3 and 4 in the same burst, each finished immediately -> grants in order 0, 3, 4.
  - Then post 3 and 0 -> order is 0, 3, because the search starts after room 4 and wraps.
- **Overwrite:** request room 1 DOOR locked, then room 1 DOOR unlocked before the grant -> one job, colour 3'b010, `aud_code`=4'b0011.
- **Clear priority:** room 4 is pending and `clear_req` is pulsed while another job is in WAIT.
  - The in-flight job completes with its audio cue.
  - The clear runs next: `draw_clear`=1, x/y/colour=0, no audio, `pending`=0.
- **Timeout:** set TIMEOUT=16 and never assert `countDone` -> `timeout_err`=1 after 16 cycles in WAIT, no `aud_valid`, next pending job proceeds.
